sc_goal_sequencer: RTL

Game-flow controller for the two-slot goal entry register in the Frogger datapath. It turns frog-arrival events at the left and right goal slots into single-cycle enter strobes, detects landings on an already-filled slot, and runs the level-complete sequence when both slots fill: celebrate, clear the entry register, advance the level. It sits between the frog collision logic and the entry register, and drives respawn and level information to the game top level.

---
 rtl/sc_goal_pkg.sv | 17 +
 rtl/sc_goal_timer.sv | 26 ++
 rtl/sc_goal_sequencer.sv | 128 ++++++++++++
 3 files changed

// File: rtl/sc_goal_pkg.sv
// Shared definitions for the goal sequencer: controller state encoding and
// the bit positions of the two goal slots inside the entry-register flags.
package sc_goal_pkg;

    typedef enum logic [2:0] {
        PLAY      = 3'd0,
        COMMIT    = 3'd1,
        WAIT_REG  = 3'd2,
        CELEBRATE = 3'd3,
        CLEAR     = 3'd4,
        WIN       = 3'd5
    } goalState_t;

    localparam logic SLOT_LEFT  = 1'b1;
    localparam logic SLOT_RIGHT = 1'b0;

endpackage

// File: rtl/sc_goal_timer.sv
// Loadable down-counter that times the celebration; done is high while the
// count sits at zero, so loading CYCLES-1 yields exactly CYCLES busy cycles.
module sc_goal_timer #(
    parameter int CYCLES = 50_000_000,
    localparam int W = $clog2(CYCLES + 1)
) (
    input  logic clock,
    input  logic resetLow,
    input  logic load,
    output logic done
);

    logic [W-1:0] count;

    always_ff @(posedge clock or negedge resetLow) begin
        if (!resetLow)
            count <= '0;
        else if (load)
            count <= W'(CYCLES - 1);
        else if (count != '0)
            count <= count - W'(1);
    end

    assign done = (count == '0);

endmodule

// File: rtl/sc_goal_sequencer.sv
// Goal-slot flow controller: turns frog arrivals into enter strobes, flags
// landings on filled slots, and runs celebrate/clear/level-up when both fill.
module sc_goal_sequencer
    import sc_goal_pkg::*;
#(
    parameter int CELEBRATE_CYCLES = 50_000_000,
    parameter int LEVEL_W          = 4,
    parameter int MAX_LEVEL        = 9
) (
    input  logic               SC_GoalSEQ_CLOCK_50,
    input  logic               SC_GoalSEQ_RESET_InLow,
    input  logic               SC_GoalSEQ_arriveLeft_InLow,
    input  logic               SC_GoalSEQ_arriveRight_InLow,
    input  logic [1:0]         SC_GoalSEQ_numEntry_In,
    output logic               SC_GoalSEQ_enterLeft_OutLow,
    output logic               SC_GoalSEQ_enterRight_OutLow,
    output logic               SC_GoalSEQ_clearEntry_OutHigh,
    output logic               SC_GoalSEQ_respawn_OutLow,
    output logic               SC_GoalSEQ_death_OutLow,
    output logic               SC_GoalSEQ_levelUp_OutLow,
    output logic [LEVEL_W-1:0] SC_GoalSEQ_level_Out,
    output logic               SC_GoalSEQ_busy_Out,
    output logic               SC_GoalSEQ_win_Out
);

    localparam logic [LEVEL_W-1:0] LEVEL_LAST = LEVEL_W'(MAX_LEVEL);

    goalState_t         state, nextState;
    logic               slot, nextSlot;
    logic [LEVEL_W-1:0] nextLevel;
    logic               timerLoad, timerDone;
    logic               nextRespawn, nextDeath, nextClear, nextLevelUp;

    sc_goal_timer #(.CYCLES(CELEBRATE_CYCLES)) celebrateTimer (
        .clock    (SC_GoalSEQ_CLOCK_50),
        .resetLow (SC_GoalSEQ_RESET_InLow),
        .load     (timerLoad),
        .done     (timerDone)
    );

    // Outputs are registered from the next-state decode, so each pulse lines
    // up with the cycle of the state that owns it.
    always_comb begin
        nextState   = state;
        nextSlot    = slot;
        nextLevel   = SC_GoalSEQ_level_Out;
        timerLoad   = 1'b0;
        nextRespawn = 1'b1;
        nextDeath   = 1'b1;
        nextClear   = 1'b0;
        nextLevelUp = 1'b1;
        case (state)
            PLAY: begin
                if (!SC_GoalSEQ_arriveLeft_InLow) begin
                    if (SC_GoalSEQ_numEntry_In[SLOT_LEFT]) begin
                        nextDeath   = 1'b0;
                        nextRespawn = 1'b0;
                    end else begin
                        nextSlot  = SLOT_LEFT;
                        nextState = COMMIT;
                    end
                end else if (!SC_GoalSEQ_arriveRight_InLow) begin
                    if (SC_GoalSEQ_numEntry_In[SLOT_RIGHT]) begin
                        nextDeath   = 1'b0;
                        nextRespawn = 1'b0;
                    end else begin
                        nextSlot  = SLOT_RIGHT;
                        nextState = COMMIT;
                    end
                end
            end
            COMMIT: nextState = WAIT_REG;
            WAIT_REG: begin
                if (SC_GoalSEQ_numEntry_In == 2'b11) begin
                    timerLoad = 1'b1;
                    nextState = CELEBRATE;
                end else begin
                    nextRespawn = 1'b0;
                    nextState   = PLAY;
                end
            end
            CELEBRATE: begin
                if (timerDone) begin
                    nextState   = CLEAR;
                    nextClear   = 1'b1;
                    nextLevelUp = 1'b0;
                    nextRespawn = 1'b0;
                end
            end
            CLEAR: begin
                if (SC_GoalSEQ_level_Out != LEVEL_LAST)
                    nextLevel = SC_GoalSEQ_level_Out + LEVEL_W'(1);
                nextState = (nextLevel == LEVEL_LAST) ? WIN : PLAY;
            end
            WIN:     nextState = WIN;
            default: nextState = PLAY;
        endcase
    end

    always_ff @(posedge SC_GoalSEQ_CLOCK_50 or negedge SC_GoalSEQ_RESET_InLow) begin
        if (!SC_GoalSEQ_RESET_InLow) begin
            state                         <= PLAY;
            slot                          <= SLOT_LEFT;
            SC_GoalSEQ_enterLeft_OutLow   <= 1'b1;
            SC_GoalSEQ_enterRight_OutLow  <= 1'b1;
            SC_GoalSEQ_clearEntry_OutHigh <= 1'b0;
            SC_GoalSEQ_respawn_OutLow     <= 1'b1;
            SC_GoalSEQ_death_OutLow       <= 1'b1;
            SC_GoalSEQ_levelUp_OutLow     <= 1'b1;
            SC_GoalSEQ_level_Out          <= '0;
            SC_GoalSEQ_busy_Out           <= 1'b0;
            SC_GoalSEQ_win_Out            <= 1'b0;
        end else begin
            state                         <= nextState;
            slot                          <= nextSlot;
            SC_GoalSEQ_enterLeft_OutLow   <= !(nextState == COMMIT && nextSlot == SLOT_LEFT);
            SC_GoalSEQ_enterRight_OutLow  <= !(nextState == COMMIT && nextSlot == SLOT_RIGHT);
            SC_GoalSEQ_clearEntry_OutHigh <= nextClear;
            SC_GoalSEQ_respawn_OutLow     <= nextRespawn;
            SC_GoalSEQ_death_OutLow       <= nextDeath;
            SC_GoalSEQ_levelUp_OutLow     <= nextLevelUp;
            SC_GoalSEQ_level_Out          <= nextLevel;
            SC_GoalSEQ_busy_Out           <= (nextState != PLAY);
            SC_GoalSEQ_win_Out            <= (nextState == WIN);
        end
    end

endmodule
